keep_pack: RTL and testbench

- AXI-Stream byte packer for the UDT/UDP datapath.
- Accepts beats whose tkeep may be sparse or non-contiguous, including all-zero keep.
- Re-emits the same byte sequence with dense lanes: every non-last beat has all keep bits set, and the last beat's keep is contiguous from lane 0.
- Sits between a sparse-keep producer and any consumer that requires contiguous keep. It is the producing/normalising counterpart of the contiguous-keep transfer stage.

---
 rtl/keep_pack_if.sv | 29 ++
 rtl/keep_pack.sv | 144 ++++++++++++++
 tb/tb_keep_pack.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keep_pack_if.sv
// AXI-Stream beat bundle carrying data, byte enables and frame delimiter.
// The master modport is the beat producer; the slave modport is the consumer.
interface keep_pack_if #(
    parameter int C_S_AXI_DATA_WIDTH = 64
);
  localparam int B = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] tdata;
  logic [B-1:0]                  tkeep;
  logic                          tvalid;
  logic                          tready;
  logic                          tlast;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/keep_pack.sv
// AXI-Stream byte packer: compacts sparse tkeep beats into dense beats whose
// last beat has keep contiguous from lane 0, preserving byte order per frame.
module keep_pack #(
    parameter int C_S_AXI_DATA_WIDTH = 64
) (
    input  logic         core_clk,
    input  logic         core_rst,
    keep_pack_if.slave   in_axis,
    keep_pack_if.master  out_axis
);
  localparam int B  = C_S_AXI_DATA_WIDTH / 8;
  localparam int CW = $clog2(2 * B);
  localparam logic [CW-1:0] B_CNT = CW'(B);

  typedef enum logic {
    RUN,
    FLUSH
  } mode_t;

  mode_t                         mode_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_reg;
  logic [CW-1:0]                 c_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] out_data_reg;
  logic [B-1:0]                  out_keep_reg;
  logic                          out_last_reg;
  logic                          out_valid_reg;

  logic [7:0]                    in_lane [B];
  logic [7:0]                    s_bytes [2*B];
  logic [CW-1:0]                 pos     [B+1];
  logic [CW-1:0]                 t_sum;
  logic [C_S_AXI_DATA_WIDTH-1:0] lo_data;
  logic [C_S_AXI_DATA_WIDTH-1:0] hi_data;
  logic [B-1:0]                  lo_keep;
  logic [B-1:0]                  flush_keep;
  logic                          out_free;
  logic                          in_ready;
  logic                          accept;
  logic                          t_ge_b;

  generate
    for (genvar gi = 0; gi < B; gi++) begin : g_lane
      assign in_lane[gi] = in_axis.tdata[8*gi +: 8];
    end
  endgenerate

  // Build the frame byte stream S = residue followed by the compacted input
  // bytes; each kept lane lands at C plus the number of kept lanes below it.
  always_comb begin
    pos[0] = '0;
    for (int i = 0; i < B; i++) begin
      pos[i+1] = pos[i] + CW'(in_axis.tkeep[i]);
    end
    t_sum = c_reg + pos[B];
    for (int j = 0; j < 2 * B; j++) begin
      s_bytes[j] = 8'h00;
    end
    for (int j = 0; j < B; j++) begin
      s_bytes[j] = r_reg[8*j +: 8];
    end
    for (int i = 0; i < B; i++) begin
      if (in_axis.tkeep[i]) begin
        s_bytes[c_reg + pos[i]] = in_lane[i];
      end
    end
  end

  // Lanes beyond the stream length are forced to zero so that unused output
  // lanes and unused residue bytes are always clean.
  generate
    for (genvar gi = 0; gi < B; gi++) begin : g_slice
      assign lo_data[8*gi +: 8] = (CW'(gi) < t_sum) ? s_bytes[gi] : 8'h00;
      assign hi_data[8*gi +: 8] = (CW'(B + gi) < t_sum) ? s_bytes[B + gi] : 8'h00;
      assign lo_keep[gi]        = (CW'(gi) < t_sum);
      assign flush_keep[gi]     = (CW'(gi) < c_reg);
    end
  endgenerate

  assign t_ge_b   = (t_sum >= B_CNT);
  assign out_free = !out_valid_reg || out_axis.tready;
  assign in_ready = !core_rst && (mode_reg == RUN) && out_free;
  assign accept   = in_axis.tvalid && in_ready;

  assign in_axis.tready  = in_ready;
  assign out_axis.tdata  = out_data_reg;
  assign out_axis.tkeep  = out_keep_reg;
  assign out_axis.tlast  = out_last_reg;
  assign out_axis.tvalid = out_valid_reg;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      mode_reg      <= RUN;
      r_reg         <= '0;
      c_reg         <= '0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && out_axis.tready) begin
        out_valid_reg <= 1'b0;
      end
      case (mode_reg)
        RUN: begin
          if (accept) begin
            if (t_ge_b) begin
              out_data_reg  <= lo_data;
              out_keep_reg  <= '1;
              out_valid_reg <= 1'b1;
              out_last_reg  <= in_axis.tlast && (t_sum == B_CNT);
              r_reg         <= hi_data;
              c_reg         <= t_sum - B_CNT;
              // Leftover bytes of a finished frame need their own beat.
              if (in_axis.tlast && (t_sum != B_CNT)) begin
                mode_reg <= FLUSH;
              end
            end else if (!in_axis.tlast) begin
              r_reg <= lo_data;
              c_reg <= t_sum;
            end else begin
              out_data_reg  <= lo_data;
              out_keep_reg  <= lo_keep;
              out_last_reg  <= 1'b1;
              out_valid_reg <= 1'b1;
              r_reg         <= '0;
              c_reg         <= '0;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            out_data_reg  <= r_reg;
            out_keep_reg  <= flush_keep;
            out_last_reg  <= 1'b1;
            out_valid_reg <= 1'b1;
            r_reg         <= '0;
            c_reg         <= '0;
            mode_reg      <= RUN;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keep_pack.sv
// Randomised scoreboard bench for keep_pack: whole-frame expectations are
// derived from the kept byte stream and matched by an independent monitor.
module tb_keep_pack;
  localparam int W = 64;
  localparam int B = W / 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [B-1:0] keep;
    logic         last;
  } beat_t;

  logic core_clk = 1'b0;
  logic core_rst = 1'b1;

  keep_pack_if #(.C_S_AXI_DATA_WIDTH(W)) in_if ();
  keep_pack_if #(.C_S_AXI_DATA_WIDTH(W)) out_if ();

  keep_pack #(.C_S_AXI_DATA_WIDTH(W)) dut (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .in_axis  (in_if),
    .out_axis (out_if)
  );

  initial forever #5 core_clk = ~core_clk;

  beat_t        exp_q[$];
  logic [W-1:0] fr_data[$];
  logic [B-1:0] fr_keep[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           tready_mode = 0;  // 0: always ready, 1: random, 2: never ready
  int           beat_no = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected output of one frame from its kept byte stream: full beats as
  // bytes accumulate; the final full beat carries last only if the closing
  // input beat completed it, otherwise a (possibly empty) tail beat follows.
  task automatic model_frame();
    logic [7:0] bytes[$];
    int    p, n, full, rem;
    beat_t e;
    p = 0;
    for (int b = 0; b < fr_data.size(); b++) begin
      if (b == fr_data.size() - 1) p = bytes.size();
      for (int l = 0; l < B; l++)
        if (fr_keep[b][l]) bytes.push_back(fr_data[b][8*l +: 8]);
    end
    n    = bytes.size();
    full = n / B;
    rem  = n % B;
    for (int c = 0; c < full; c++) begin
      e.data = '0;
      for (int l = 0; l < B; l++) e.data[8*l +: 8] = bytes[c*B + l];
      e.keep = '1;
      e.last = (rem == 0) && (n > p) && (c == full - 1);
      exp_q.push_back(e);
    end
    if (!((rem == 0) && (n > p))) begin
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < rem; l++) begin
        e.data[8*l +: 8] = bytes[full*B + l];
        e.keep[l]        = 1'b1;
      end
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Entered and left at posedge+1; the beat transfers on the first posedge
  // that follows a negedge with in_tready high.
  task automatic send_beat(input logic [W-1:0] d, input logic [B-1:0] k, input logic l,
                           output int waits);
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge core_clk);
      if (in_if.tready) break;
      waits++;
      if (waits > 500) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_tready_timeout: got 0 expected 1 within 500 cycles");
        break;
      end
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic send_frame();
    int w;
    model_frame();
    for (int b = 0; b < fr_data.size(); b++)
      send_beat(fr_data[b], fr_keep[b], (b == fr_data.size() - 1), w);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic add_beat(input logic [W-1:0] d, input logic [B-1:0] k);
    fr_data.push_back(d);
    fr_keep.push_back(k);
  endtask

  task automatic new_frame();
    fr_data.delete();
    fr_keep.delete();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(posedge core_clk);
      #1;
      t++;
    end
    check("drain_pending", W'(exp_q.size()), '0);
  endtask

  // Downstream ready, updated between edges away from the driver's slot.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge core_clk);
      #2;
      case (tready_mode)
        1:       out_if.tready = 1'($urandom_range(0, 1));
        2:       out_if.tready = 1'b0;
        default: out_if.tready = 1'b1;
      endcase
    end
  end

  // Monitor: pops one expectation per output transfer, checks hold stability.
  initial begin
    beat_t e;
    beat_t held;
    logic  hold_pending;
    hold_pending = 1'b0;
    held = '0;
    forever begin
      @(negedge core_clk);
      if (core_rst) begin
        hold_pending = 1'b0;
        continue;
      end
      if (hold_pending) begin
        check("hold_valid", W'(out_if.tvalid), W'(1'b1));
        check("hold_data", out_if.tdata, held.data);
        check("hold_keep", W'(out_if.tkeep), W'(held.keep));
        check("hold_last", W'(out_if.tlast), W'(held.last));
      end
      hold_pending = out_if.tvalid && !out_if.tready;
      held.data = out_if.tdata;
      held.keep = out_if.tkeep;
      held.last = out_if.tlast;
      if (out_if.tvalid && out_if.tready) begin
        beat_no++;
        $display("out beat %0d: data=%h keep=%h last=%b", beat_no,
                 out_if.tdata, out_if.tkeep, out_if.tlast);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got keep=%h data=%h expected no beat",
                   out_if.tkeep, out_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_if.tdata, e.data);
          check("out_keep", W'(out_if.tkeep), W'(e.keep));
          check("out_last", W'(out_if.tlast), W'(e.last));
        end
      end
    end
  end

  initial begin
    int w;
    logic [W-1:0] d;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;

    // Reset state.
    @(negedge core_clk);
    check("rst_in_tready", W'(in_if.tready), '0);
    @(posedge core_clk);
    #1;
    check("rst_tvalid", W'(out_if.tvalid), '0);
    check("rst_tkeep", W'(out_if.tkeep), '0);
    check("rst_tdata", out_if.tdata, '0);
    check("rst_tlast", W'(out_if.tlast), '0);
    core_rst = 1'b0;
    @(posedge core_clk);
    #1;

    // Contiguous frame: no stall, 1-cycle latency per beat.
    new_frame();
    add_beat({$urandom, $urandom}, 8'hFF);
    add_beat({$urandom, $urandom}, 8'hFF);
    add_beat({$urandom, $urandom}, 8'h0F);
    model_frame();
    for (int b = 0; b < 3; b++) begin
      send_beat(fr_data[b], fr_keep[b], (b == 2), w);
      check("t1_stall", W'(w), '0);
      check("t1_latency_valid", W'(out_if.tvalid), W'(1'b1));
    end
    in_if.tvalid = 1'b0;
    check("t1_next_ready", W'(in_if.tready), W'(1'b1));
    drain();

    // Sparse merge with a one-cycle flush stall.
    new_frame();
    add_beat(64'h0706050403020100, 8'h55);
    add_beat(64'h0F0E0D0C0B0A0908, 8'hFF);
    send_frame();
    check("t2_flush_stall", W'(in_if.tready), '0);
    @(posedge core_clk);
    #1;
    check("t2_ready_after_flush", W'(in_if.tready), W'(1'b1));
    drain();

    // Zero-keep beats mid-frame, then a zero-byte frame.
    new_frame();
    add_beat({$urandom, $urandom}, 8'hFF);
    add_beat({$urandom, $urandom}, 8'h00);
    add_beat({$urandom, $urandom}, 8'h00);
    add_beat({$urandom, $urandom}, 8'h0F);
    send_frame();
    new_frame();
    add_beat({$urandom, $urandom}, 8'h00);
    send_frame();
    drain();

    // Exact fill on the last beat: single dense beat, no stall.
    new_frame();
    add_beat(64'h0706050403020100, 8'h0F);
    add_beat(64'h0F0E0D0C0B0A0908, 8'hF0);
    send_frame();
    check("t4_no_stall", W'(in_if.tready), W'(1'b1));
    drain();

    // Random keep, random backpressure.
    tready_mode = 1;
    for (int f = 0; f < 200; f++) begin
      new_frame();
      for (int b = 0; b < int'($urandom_range(1, 5)); b++) begin
        int sel;
        logic [B-1:0] k;
        sel = int'($urandom_range(0, 9));
        k = (sel == 0) ? '0 : (sel == 1) ? '1 : B'($urandom);
        add_beat({$urandom, $urandom}, k);
      end
      send_frame();
      repeat (int'($urandom_range(0, 2))) begin
        @(posedge core_clk);
        #1;
      end
    end
    tready_mode = 0;
    drain();

    // Reset mid-frame with a held output beat and 3 bytes of residue.
    tready_mode = 2;
    repeat (2) begin
      @(posedge core_clk);
      #1;
    end
    send_beat({$urandom, $urandom}, 8'h07, 1'b0, w);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, w);
    in_if.tvalid = 1'b0;
    core_rst = 1'b1;
    @(negedge core_clk);
    check("t6_rst_in_tready", W'(in_if.tready), '0);
    @(posedge core_clk);
    #1;
    check("t6_rst_tvalid", W'(out_if.tvalid), '0);
    check("t6_rst_tkeep", W'(out_if.tkeep), '0);
    check("t6_rst_tdata", out_if.tdata, '0);
    check("t6_rst_tlast", W'(out_if.tlast), '0);
    core_rst = 1'b0;
    tready_mode = 0;
    repeat (2) begin
      @(posedge core_clk);
      #1;
    end
    d = {$urandom, $urandom};
    new_frame();
    add_beat(d, 8'hFF);
    send_frame();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
